// File: rtl/fifo_bank_filler_pkg.sv
//============================================================================
// fifo_fill_pkg : shared types and helpers for the FIFO bank filler
// Revision 1.0
//============================================================================
`default_nettype none

package fifo_fill_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEEK      = 3'd1,
    S_REQ       = 3'd2,
    S_WAIT_DATA = 3'd3,
    S_DRAIN     = 3'd4,
    S_FIN       = 3'd5
  } fill_state_t;

  function automatic int bytes_per_word(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_bank_filler_if.sv
//============================================================================
// fifo_bank_filler_if : Avalon-MM-style read bus between filler and memory
// Revision 1.0
//============================================================================
`default_nettype none

interface fifo_bank_filler_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              mem_read;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_waitrequest;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_readdatavalid;

  modport master (
    output mem_read,
    output mem_address,
    input  mem_waitrequest,
    input  mem_readdata,
    input  mem_readdatavalid
  );

  modport slave (
    input  mem_read,
    input  mem_address,
    output mem_waitrequest,
    output mem_readdata,
    output mem_readdatavalid
  );
endinterface

`default_nettype wire

// File: rtl/fifo_bank_filler_serializer.sv
//============================================================================
// word_serializer : holds one memory word and emits it a byte at a time
// Revision 1.0
//============================================================================
`default_nettype none

module word_serializer
  import fifo_fill_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              advance_i,
  output logic [BYTE_W-1:0] byte_o,
  output logic              last_o
);

  localparam int NBYTES = bytes_per_word(DATA_W);
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [DATA_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] w_shifted;

  // The outgoing byte always sits at the end the shift moves away from.
  if (MSB_FIRST) begin : g_msb_first
    assign byte_o    = word_q[DATA_W-1 -: BYTE_W];
    assign w_shifted = word_q << BYTE_W;
  end else begin : g_lsb_first
    assign byte_o    = word_q[BYTE_W-1:0];
    assign w_shifted = word_q >> BYTE_W;
  end

  assign last_o = (cnt_q == CNT_W'(NBYTES - 1));

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      word_d = word_i;
      cnt_d  = '0;
    end else if (advance_i) begin
      word_d = w_shifted;
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_bank_filler.sv
//============================================================================
// fifo_bank_filler : fills every enabled byte FIFO from one memory word each
// Revision 1.0
//============================================================================
`default_nettype none

module fifo_bank_filler
  import fifo_fill_pkg::*;
#(
  parameter int NUM_CH      = 9,
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 32,
  parameter int ADDR_STRIDE = 1,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [NUM_CH-1:0]   ch_mask_i,
  fifo_bank_filler_if.master  mem,
  input  logic [NUM_CH-1:0]   fifo_full_i,
  output logic [NUM_CH-1:0]   fifo_wren_o,
  output logic [BYTE_W-1:0]   fifo_data_o,
  output logic                busy_o,
  output logic                done_o
);

  // One extra code point so the index can step past the last channel.
  localparam int IDX_W = $clog2(NUM_CH + 1);

  fill_state_t       state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              read_q, read_d;

  logic              w_found;
  logic [IDX_W-1:0]  w_sel;
  logic              w_load;
  logic              w_wr;
  logic              w_last;
  logic [BYTE_W-1:0] w_byte;

  // Descending scan so the lowest qualifying channel is the one that sticks.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (mask_q[c] && (IDX_W'(c) >= idx_q)) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(c);
      end
    end
  end

  always_comb begin
    fifo_wren_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      fifo_wren_o[c] = (state_q == S_DRAIN) && (idx_q == IDX_W'(c)) && !fifo_full_i[c];
    end
  end

  assign w_wr = |fifo_wren_o;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    base_d  = base_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    read_d  = read_q;
    w_load  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mask_d  = ch_mask_i;
          base_d  = base_addr_i;
          idx_d   = '0;
          state_d = S_SEEK;
        end
      end
      S_SEEK: begin
        if (w_found) begin
          idx_d   = w_sel;
          addr_d  = base_q + ADDR_W'(w_sel) * ADDR_W'(ADDR_STRIDE);
          read_d  = 1'b1;
          state_d = S_REQ;
        end else begin
          state_d = S_FIN;
        end
      end
      S_REQ: begin
        if (!mem.mem_waitrequest) begin
          read_d  = 1'b0;
          state_d = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (mem.mem_readdatavalid) begin
          w_load  = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_wr && w_last) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_SEEK;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      read_q  <= read_d;
    end
  end

  word_serializer #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_serializer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (w_load),
    .word_i    (mem.mem_readdata),
    .advance_i (w_wr),
    .byte_o    (w_byte),
    .last_o    (w_last)
  );

  assign mem.mem_read    = read_q;
  assign mem.mem_address = addr_q;
  assign fifo_data_o     = w_byte;
  assign busy_o          = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done_o          = (state_q == S_FIN);

endmodule

`default_nettype wire

// File: tb/tb_fifo_bank_filler.sv
//============================================================================
// tb_fifo_bank_filler : table-driven scoreboard bench, LSB/stride-1 and MSB/stride-4 DUTs
// Revision 1.0
//============================================================================
`default_nettype none

module tb_fifo_bank_filler;

  typedef struct {
    int          inst;
    logic [31:0] base;
    logic [8:0]  mask;
    int          stall_req;
    int          stall_len;
    int          full_ch;
    int          full_after;
    int          full_len;
    int          ill_at;
    bit          start_in_done;
    int          exp_cycles;
    int          exp_reads;
  } vec_t;

  typedef struct packed {
    logic [3:0] ch;
    logic [7:0] data;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        start [2];
  logic [31:0] base  [2];
  logic [8:0]  mask  [2];
  logic [8:0]  full  [2];
  logic [8:0]  wren  [2];
  logic [7:0]  fdata [2];
  logic        busy  [2];
  logic        done  [2];
  logic        rd    [2];
  logic [31:0] addr  [2];
  logic        wreq  [2];
  logic [63:0] rdata [2];
  logic        rdv   [2];

  fifo_bank_filler_if #(.ADDR_W(32), .DATA_W(64)) mif0 ();
  fifo_bank_filler_if #(.ADDR_W(32), .DATA_W(64)) mif1 ();

  assign mif0.mem_waitrequest   = wreq[0];
  assign mif0.mem_readdata      = rdata[0];
  assign mif0.mem_readdatavalid = rdv[0];
  assign rd[0]                  = mif0.mem_read;
  assign addr[0]                = mif0.mem_address;
  assign mif1.mem_waitrequest   = wreq[1];
  assign mif1.mem_readdata      = rdata[1];
  assign mif1.mem_readdatavalid = rdv[1];
  assign rd[1]                  = mif1.mem_read;
  assign addr[1]                = mif1.mem_address;

  fifo_bank_filler #(
    .NUM_CH(9), .DATA_W(64), .ADDR_W(32), .ADDR_STRIDE(1), .MSB_FIRST(1'b0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]), .base_addr_i(base[0]),
    .ch_mask_i(mask[0]), .mem(mif0), .fifo_full_i(full[0]), .fifo_wren_o(wren[0]),
    .fifo_data_o(fdata[0]), .busy_o(busy[0]), .done_o(done[0])
  );

  fifo_bank_filler #(
    .NUM_CH(9), .DATA_W(64), .ADDR_W(32), .ADDR_STRIDE(4), .MSB_FIRST(1'b1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]), .base_addr_i(base[1]),
    .ch_mask_i(mask[1]), .mem(mif1), .fifo_full_i(full[1]), .fifo_wren_o(wren[1]),
    .fifo_data_o(fdata[1]), .busy_o(busy[1]), .done_o(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t        vecs [6];
  vec_t        cfg;
  int          cur;
  int          k;
  bit          acc_pending;
  logic [31:0] acc_addr;
  bit          prev_stall;
  logic [31:0] prev_addr;
  int          wcnt, fcnt, req_idx;
  int          nbytes [9];
  int          busy_cnt, done_cnt, done_at, reads;
  logic [31:0] exp_addr [$];
  wr_t         exp_wr [$];

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return 64'h0102030405060708 + 64'(a) * 64'h1010101010101010;
  endfunction

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_expect(input int inst, input logic [31:0] b, input logic [8:0] m);
    logic [63:0] w;
    logic [31:0] a;
    wr_t         e;
    for (int c = 0; c < 9; c++) begin
      if (m[c]) begin
        a = b + 32'(c) * ((inst == 1) ? 32'd4 : 32'd1);
        exp_addr.push_back(a);
        w = mem_word(a);
        for (int i = 0; i < 8; i++) begin
          e.ch   = 4'(c);
          e.data = (inst == 1) ? 8'(w >> (56 - 8 * i)) : 8'(w >> (8 * i));
          exp_wr.push_back(e);
        end
      end
    end
  endtask

  task automatic do_cycle();
    int          wc;
    wr_t         e;
    logic [31:0] ea;
    @(negedge clk);
    start[0] = 1'b0;
    start[1] = 1'b0;
    rdv[cur] = 1'b0;
    wreq[cur] = 1'b0;
    full[cur] = '0;
    if (acc_pending) begin
      rdv[cur]    = 1'b1;
      rdata[cur]  = mem_word(acc_addr);
      acc_pending = 1'b0;
    end
    // Stall the chosen request; a stray readdatavalid during it must be ignored.
    if (rd[cur] && req_idx == cfg.stall_req && wcnt < cfg.stall_len) begin
      wreq[cur]  = 1'b1;
      rdv[cur]   = 1'b1;
      rdata[cur] = 64'hDEAD_BEEF_0BAD_F00D;
      wcnt++;
    end
    if (cfg.full_len > 0 && nbytes[cfg.full_ch] == cfg.full_after && fcnt < cfg.full_len) begin
      full[cur][cfg.full_ch] = 1'b1;
      fcnt++;
    end
    #1;
    k++;
    if (prev_stall)
      check(rd[cur] && addr[cur] == prev_addr, "stall_hold", {31'd0, rd[cur], addr[cur]}, {32'd1, prev_addr});
    prev_stall = rd[cur] && wreq[cur];
    prev_addr  = addr[cur];
    if (rd[cur] && !wreq[cur]) begin
      reads++;
      req_idx++;
      acc_pending = 1'b1;
      acc_addr    = addr[cur];
      if (exp_addr.size() == 0) begin
        check(1'b0, "unexpected_read", 64'(addr[cur]), 64'd0);
      end else begin
        ea = exp_addr.pop_front();
        check(addr[cur] == ea, "read_addr", 64'(addr[cur]), 64'(ea));
      end
    end
    if (full[cur] != '0)
      check((wren[cur] & full[cur]) == '0, "wren_while_full", 64'(wren[cur]), 64'd0);
    if (wren[cur] != '0) begin
      check($onehot(wren[cur]), "wren_onehot", 64'(wren[cur]), 64'd0);
      wc = 0;
      for (int c = 0; c < 9; c++) if (wren[cur][c]) wc = c;
      nbytes[wc]++;
      if (exp_wr.size() == 0) begin
        check(1'b0, "extra_write", (64'(wc) << 8) | 64'(fdata[cur]), 64'd0);
      end else begin
        e = exp_wr.pop_front();
        check(4'(wc) == e.ch && fdata[cur] == e.data, "fifo_write",
              (64'(wc) << 8) | 64'(fdata[cur]), (64'(e.ch) << 8) | 64'(e.data));
      end
    end
    if (busy[cur]) busy_cnt++;
    if (done[cur]) begin
      done_cnt++;
      if (done_cnt == 1) done_at = k;
    end
    if (k == cfg.ill_at) begin
      start[cur] = 1'b1;
      base[cur]  = 32'hDEAD_0000;
      mask[cur]  = 9'h001;
    end
    if (done[cur] && cfg.start_in_done) begin
      start[cur] = 1'b1;
      mask[cur]  = 9'h1FF;
    end
  endtask

  task automatic clear_run();
    acc_pending = 1'b0;
    prev_stall  = 1'b0;
    wcnt = 0; fcnt = 0; req_idx = 0;
    busy_cnt = 0; done_cnt = 0; done_at = 0; reads = 0; k = 0;
    for (int c = 0; c < 9; c++) nbytes[c] = 0;
  endtask

  initial begin
    vecs[0] = '{inst:0, base:32'h0,         mask:9'h1FF, stall_req:-1, stall_len:0, full_ch:0, full_after:0, full_len:0, ill_at:20, start_in_done:1'b1, exp_cycles:100, exp_reads:9};
    vecs[1] = '{inst:1, base:32'h0,         mask:9'h1FF, stall_req:-1, stall_len:0, full_ch:0, full_after:0, full_len:0, ill_at:0,  start_in_done:1'b0, exp_cycles:100, exp_reads:9};
    vecs[2] = '{inst:1, base:32'h100,       mask:9'h105, stall_req:-1, stall_len:0, full_ch:0, full_after:0, full_len:0, ill_at:0,  start_in_done:1'b0, exp_cycles:34,  exp_reads:3};
    vecs[3] = '{inst:0, base:32'h0,         mask:9'h000, stall_req:-1, stall_len:0, full_ch:0, full_after:0, full_len:0, ill_at:0,  start_in_done:1'b1, exp_cycles:1,   exp_reads:0};
    vecs[4] = '{inst:0, base:32'h40,        mask:9'h1FF, stall_req:2,  stall_len:5, full_ch:3, full_after:3, full_len:4, ill_at:0,  start_in_done:1'b0, exp_cycles:109, exp_reads:9};
    vecs[5] = '{inst:0, base:32'hFFFF_FFFC, mask:9'h1F0, stall_req:-1, stall_len:0, full_ch:0, full_after:0, full_len:0, ill_at:0,  start_in_done:1'b0, exp_cycles:56,  exp_reads:5};

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; base[i] = '0; mask[i] = '0; full[i] = '0;
      wreq[i] = 1'b0; rdata[i] = '0; rdv[i] = 1'b0;
    end
    cfg = vecs[0];
    cur = 0;
    clear_run();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check(!rd[i] && addr[i] == 32'd0, "reset_mem", {31'd0, rd[i], addr[i]}, 64'd0);
      check(wren[i] == '0 && fdata[i] == 8'd0 && !busy[i] && !done[i], "reset_fifo_ctl",
            {46'd0, busy[i], done[i], wren[i], fdata[i]}, 64'd0);
    end
    rst_n = 1'b1;

    for (int t = 0; t < 6; t++) begin
      cfg = vecs[t];
      cur = cfg.inst;
      clear_run();
      exp_addr.delete();
      exp_wr.delete();
      push_expect(cur, cfg.base, cfg.mask);
      @(negedge clk);
      start[cur] = 1'b1;
      base[cur]  = cfg.base;
      mask[cur]  = cfg.mask;
      while (k < 400 && !(done_cnt > 0 && k >= done_at + 3)) do_cycle();
      check(done_cnt == 1, "done_count", 64'(done_cnt), 64'd1);
      check(busy_cnt == cfg.exp_cycles, "busy_cycles", 64'(busy_cnt), 64'(cfg.exp_cycles));
      check(done_at == cfg.exp_cycles + 1, "done_latency", 64'(done_at), 64'(cfg.exp_cycles + 1));
      check(reads == cfg.exp_reads, "read_count", 64'(reads), 64'(cfg.exp_reads));
      check(exp_wr.size() == 0, "bytes_missing", 64'(exp_wr.size()), 64'd0);
      check(exp_addr.size() == 0, "reads_missing", 64'(exp_addr.size()), 64'd0);
    end

    // Reset in the middle of draining channel 4.
    cfg = vecs[1];
    cfg.inst = 0;
    cur = 0;
    clear_run();
    exp_addr.delete();
    exp_wr.delete();
    push_expect(0, 32'h0, 9'h1FF);
    @(negedge clk);
    start[0] = 1'b1;
    base[0]  = 32'h0;
    mask[0]  = 9'h1FF;
    while (k < 200 && nbytes[4] < 3) do_cycle();
    check(nbytes[4] == 3, "reach_ch4_drain", 64'(nbytes[4]), 64'd3);
    @(negedge clk);
    rst_n   = 1'b0;
    rdv[0]  = 1'b0;
    wreq[0] = 1'b0;
    full[0] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check(!rd[0] && addr[0] == 32'd0, "midrst_mem", {31'd0, rd[0], addr[0]}, 64'd0);
    check(wren[0] == '0 && fdata[0] == 8'd0 && !busy[0] && !done[0], "midrst_fifo_ctl",
          {46'd0, busy[0], done[0], wren[0], fdata[0]}, 64'd0);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        #1;
        if (wren[0] != '0 || rd[0] || busy[0] || done[0]) bad++;
      end
      check(bad == 0, "quiet_after_reset", 64'(bad), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
